fat32_volume_mount: RTL and testbench
=====================================

Name: fat32_volume_mount

Overview:
Mount sequencer that sits between the SD sector-read engine and the file-system block. It requests sector 0 (MBR), then the partition boot sector (BPB). It parses both from the streamed byte interface, validates them, and computes the absolute FAT, data-region and root-directory sectors. Its outputs feed the file-system block directly: fileSystemSector, SectorsPerCluster and RootClusterNumber. It replaces free-running edge-triggered field capture with a single-clock, checked sequence.

Parameters:
SECTOR_BYTES, 512, bytes per sector; the BPB BytesPerSector field must equal this.
ADDR_W, 9, width of the byte-address bus.
MAX_FATS, 4, largest accepted NumberOfFAT value.

Ports:
Clock  in  1  system clock; all logic on rising edge.
sys_rst_n  in  1  reset, synchronous, active-low.
start  in  1  one-cycle pulse; begins a mount from IDLE, DONE or ERROR; ignored otherwise.
readRequest  out  1  level; held high until readAck.
readSector  out  32  sector to read; stable while readRequest is high.
readAck  in  1  one-cycle pulse; read accepted.
byteValid  in  1  qualifies byteAddress and byteData.
byteAddress  in  ADDR_W  byte offset within the sector.
byteData  in  8  sector byte.
sectorDone  in  1  pulse after the last byte of the sector.
busy  out  1  high in any state other than IDLE, DONE or ERROR.
mountDone  out  1  level; high in DONE.
mountError  out  1  level; high in ERROR.
errorCode  out  3  0 none, 1 MBR signature, 2 partition type, 3 BPB signature or sector size, 4 geometry.
partitionStart  out  32  partition LBA (MBR offsets 0x1C6..0x1C9).
fatStart  out  32  partitionStart + ReservedSectors.
dataStart  out  32  fatStart + NumberOfFAT*FATLength.
rootDirSector  out  32  dataStart + (RootClusterNumber-2)*SectorsPerCluster.
SectorsPerCluster  out  8  BPB offset 0x0D.
RootClusterNumber  out  32  BPB offsets 0x2C..0x2F.
ReservedSectors  out  16  BPB offsets 0x0E..0x0F.

Behaviour:
- Reset (sys_rst_n low at a clock edge): state goes to IDLE. All outputs and captured fields go to 0. Reset mid-transfer aborts immediately; bytes still in flight are ignored.
- States and transitions:
  - IDLE -> REQ_MBR on start.
  - REQ_MBR: readSector=0, readRequest=1. Goes to RX_MBR on readAck.
  - RX_MBR: capture bytes. Goes to CHK_MBR on sectorDone.
  - CHK_MBR (1 cycle): goes to REQ_BPB, or to ERROR on a failed check.
  - REQ_BPB: readSector=partitionStart. Goes to RX_BPB on readAck.
  - RX_BPB: goes to CHK_BPB on sectorDone.
  - CHK_BPB (1 cycle).
  - CALC_FAT: one addition per cycle.
  - CALC_ROOT (1 cycle).
  - DONE.
- Byte capture: bytes are accepted only in the RX states with byteValid=1. Fields are little-endian (lowest address is the LSB).
  - MBR bytes captured: 0x1C2 (partition type), 0x1C6..0x1C9, 0x1FE, 0x1FF.
  - BPB bytes captured: 0x0B..0x0C, 0x0D, 0x0E..0x0F, 0x10, 0x24..0x27 (FATLength), 0x2C..0x2F, 0x1FE, 0x1FF.
  - Bytes at other addresses, and bytes arriving in any other state, are ignored.
  - Duplicate addresses: the last write wins.
- CHK_MBR checks:
  - Signature bytes must be 0x55 then 0xAA; otherwise errorCode 1.
  - Partition type must be 0x0B or 0x0C; otherwise errorCode 2.
- CHK_BPB checks:
  - Signature 0x55/0xAA and BytesPerSector == SECTOR_BYTES; otherwise errorCode 3.
  - SectorsPerCluster must be a nonzero power of two.
  - NumberOfFAT must be in 1..MAX_FATS.
  - RootClusterNumber must be >= 2.
  - Any geometry failure gives errorCode 4.
  - On success: fatStart is loaded, and the accumulator is loaded with fatStart.
- CALC_FAT: adds FATLength to the accumulator NumberOfFAT times, one add per cycle. It then loads dataStart.
- CALC_ROOT: rootDirSector = dataStart + ((RootClusterNumber-2) << log2(SectorsPerCluster)).
- Arithmetic: all sums are 32-bit modulo 2^32; overflow is not flagged.
- Latency from the sectorDone of the BPB to mountDone=1 is 2 + NumberOfFAT cycles.
- Terminal states:
  - DONE and ERROR hold all outputs until start or reset.
  - start in DONE or ERROR clears mountDone, mountError and errorCode the next cycle, and re-enters REQ_MBR.
  - Result outputs keep their old values until overwritten.
- Simultaneous events:
  - readAck outside a REQ state is ignored.
  - sectorDone together with a final byteValid: the byte is captured before the check.
  - start while busy is ignored.

Decomposition:
- Package fat32_mount_pkg:
  - state enum;
  - error-code constants;
  - MBR/BPB byte-offset constants (0x1C2, 0x1C6, 0x1FE, 0x0B, 0x0D, 0x0E, 0x10, 0x24, 0x2C);
  - partition-type constants 0x0B and 0x0C.
- Sub-module le_field_capture (params BASE, BYTES): assembles a little-endian field from the byte stream, gated by an enable input. It is instantiated once per field.

Test Plan:
- Valid card: MBR type 0x0C, LBA 0x00002000; BPB with 512 bytes per sector, SPC 8, reserved 32, 2 FATs, FATLength 0x3C1, root cluster 2. Required: fatStart=0x2020, dataStart=0x27A2, rootDirSector=0x27A2. The second readSector must be 0x2000. mountDone must rise 4 cycles after the BPB sectorDone.
- Same card with root cluster 5: rootDirSector=0x27BA.
- MBR byte 0x1FF=0xAB: mountError=1, errorCode=1, no second readRequest.
- BPB SPC=6: errorCode=4. BPB BytesPerSector=1024: errorCode=3.
- sys_rst_n low during RX_BPB, then start: readRequest is re-issued for sector 0, and all outputs are 0 during reset.
- start asserted in RX_MBR: ignored. start in DONE: mountDone low the next cycle and a new MBR request issued.

Source files
------------

// File: rtl/fat32_mount_pkg.sv
// Shared types and constants for the FAT32 mount sequencer: FSM states,
// error codes, MBR/BPB byte offsets and accepted partition types.
package fat32_mount_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REQ_MBR,
        ST_RX_MBR,
        ST_CHK_MBR,
        ST_REQ_BPB,
        ST_RX_BPB,
        ST_CHK_BPB,
        ST_CALC_FAT,
        ST_CALC_ROOT,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_MBR_SIG   = 3'd1;
    localparam logic [2:0] ERR_PART_TYPE = 3'd2;
    localparam logic [2:0] ERR_BPB       = 3'd3;
    localparam logic [2:0] ERR_GEOMETRY  = 3'd4;

    localparam int OFF_PART_TYPE  = 'h1C2;
    localparam int OFF_PART_LBA   = 'h1C6;
    localparam int OFF_SIGNATURE  = 'h1FE;
    localparam int OFF_BYTES_SEC  = 'h0B;
    localparam int OFF_SEC_CLUS   = 'h0D;
    localparam int OFF_RSVD_SEC   = 'h0E;
    localparam int OFF_NUM_FATS   = 'h10;
    localparam int OFF_FAT_LEN    = 'h24;
    localparam int OFF_ROOT_CLUS  = 'h2C;

    localparam logic [7:0]  PTYPE_FAT32_CHS = 8'h0B;
    localparam logic [7:0]  PTYPE_FAT32_LBA = 8'h0C;
    localparam logic [15:0] BOOT_SIG        = 16'hAA55;

    // Only meaningful for a one-hot argument; the caller validates that first.
    function automatic logic [2:0] log2_pow2(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++)
            if (v[i]) r = 3'(i);
        return r;
    endfunction

endpackage

// File: rtl/fat32_volume_mount_capture.sv
// Little-endian field capture from the streamed sector bytes; one instance
// per field, enabled only while the owning sector is being received.
module le_field_capture #(
    parameter int BASE   = 0,
    parameter int BYTES  = 1,
    parameter int ADDR_W = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               byte_valid,
    input  logic [ADDR_W-1:0]  byte_addr,
    input  logic [7:0]         byte_data,
    output logic [8*BYTES-1:0] field
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            field <= '0;
        end else if (en && byte_valid) begin
            for (int i = 0; i < BYTES; i++)
                if (byte_addr == ADDR_W'(BASE + i))
                    field[8*i +: 8] <= byte_data;
        end
    end

endmodule

// File: rtl/fat32_volume_mount.sv
// FAT32 mount sequencer: reads MBR then BPB, validates both and derives the
// absolute FAT, data-region and root-directory sectors.
module fat32_volume_mount
    import fat32_mount_pkg::*;
#(
    parameter int SECTOR_BYTES = 512,
    parameter int ADDR_W       = 9,
    parameter int MAX_FATS     = 4
) (
    input  logic              Clock,
    input  logic              sys_rst_n,
    input  logic              start,
    output logic              readRequest,
    output logic [31:0]       readSector,
    input  logic              readAck,
    input  logic              byteValid,
    input  logic [ADDR_W-1:0] byteAddress,
    input  logic [7:0]        byteData,
    input  logic              sectorDone,
    output logic              busy,
    output logic              mountDone,
    output logic              mountError,
    output logic [2:0]        errorCode,
    output logic [31:0]       partitionStart,
    output logic [31:0]       fatStart,
    output logic [31:0]       dataStart,
    output logic [31:0]       rootDirSector,
    output logic [7:0]        SectorsPerCluster,
    output logic [31:0]       RootClusterNumber,
    output logic [15:0]       ReservedSectors
);

    state_t      state_q;
    logic [31:0] acc_q;
    logic [7:0]  fat_cnt_q;

    logic        en_mbr, en_bpb;
    logic [7:0]  part_type, num_fats;
    logic [15:0] mbr_sig, bpb_sig, bytes_per_sec;
    logic [31:0] fat_len;
    logic        spc_pow2, geom_ok;

    assign en_mbr = (state_q == ST_RX_MBR);
    assign en_bpb = (state_q == ST_RX_BPB);

    le_field_capture #(.BASE(OFF_PART_TYPE), .BYTES(1), .ADDR_W(ADDR_W)) u_ptype (
        .clk(Clock), .rst_n(sys_rst_n), .en(en_mbr), .byte_valid(byteValid),
        .byte_addr(byteAddress), .byte_data(byteData), .field(part_type));
    le_field_capture #(.BASE(OFF_PART_LBA), .BYTES(4), .ADDR_W(ADDR_W)) u_plba (
        .clk(Clock), .rst_n(sys_rst_n), .en(en_mbr), .byte_valid(byteValid),
        .byte_addr(byteAddress), .byte_data(byteData), .field(partitionStart));
    le_field_capture #(.BASE(OFF_SIGNATURE), .BYTES(2), .ADDR_W(ADDR_W)) u_msig (
        .clk(Clock), .rst_n(sys_rst_n), .en(en_mbr), .byte_valid(byteValid),
        .byte_addr(byteAddress), .byte_data(byteData), .field(mbr_sig));
    le_field_capture #(.BASE(OFF_BYTES_SEC), .BYTES(2), .ADDR_W(ADDR_W)) u_bps (
        .clk(Clock), .rst_n(sys_rst_n), .en(en_bpb), .byte_valid(byteValid),
        .byte_addr(byteAddress), .byte_data(byteData), .field(bytes_per_sec));
    le_field_capture #(.BASE(OFF_SEC_CLUS), .BYTES(1), .ADDR_W(ADDR_W)) u_spc (
        .clk(Clock), .rst_n(sys_rst_n), .en(en_bpb), .byte_valid(byteValid),
        .byte_addr(byteAddress), .byte_data(byteData), .field(SectorsPerCluster));
    le_field_capture #(.BASE(OFF_RSVD_SEC), .BYTES(2), .ADDR_W(ADDR_W)) u_rsvd (
        .clk(Clock), .rst_n(sys_rst_n), .en(en_bpb), .byte_valid(byteValid),
        .byte_addr(byteAddress), .byte_data(byteData), .field(ReservedSectors));
    le_field_capture #(.BASE(OFF_NUM_FATS), .BYTES(1), .ADDR_W(ADDR_W)) u_nfat (
        .clk(Clock), .rst_n(sys_rst_n), .en(en_bpb), .byte_valid(byteValid),
        .byte_addr(byteAddress), .byte_data(byteData), .field(num_fats));
    le_field_capture #(.BASE(OFF_FAT_LEN), .BYTES(4), .ADDR_W(ADDR_W)) u_flen (
        .clk(Clock), .rst_n(sys_rst_n), .en(en_bpb), .byte_valid(byteValid),
        .byte_addr(byteAddress), .byte_data(byteData), .field(fat_len));
    le_field_capture #(.BASE(OFF_ROOT_CLUS), .BYTES(4), .ADDR_W(ADDR_W)) u_root (
        .clk(Clock), .rst_n(sys_rst_n), .en(en_bpb), .byte_valid(byteValid),
        .byte_addr(byteAddress), .byte_data(byteData), .field(RootClusterNumber));
    le_field_capture #(.BASE(OFF_SIGNATURE), .BYTES(2), .ADDR_W(ADDR_W)) u_bsig (
        .clk(Clock), .rst_n(sys_rst_n), .en(en_bpb), .byte_valid(byteValid),
        .byte_addr(byteAddress), .byte_data(byteData), .field(bpb_sig));

    assign spc_pow2 = (SectorsPerCluster != 8'd0) &&
                      ((SectorsPerCluster & (SectorsPerCluster - 8'd1)) == 8'd0);
    assign geom_ok  = spc_pow2 && (num_fats != 8'd0) && (num_fats <= 8'(MAX_FATS)) &&
                      (RootClusterNumber >= 32'd2);

    always_ff @(posedge Clock) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            acc_q         <= '0;
            fat_cnt_q     <= '0;
            readRequest   <= 1'b0;
            readSector    <= '0;
            busy          <= 1'b0;
            mountDone     <= 1'b0;
            mountError    <= 1'b0;
            errorCode     <= ERR_NONE;
            fatStart      <= '0;
            dataStart     <= '0;
            rootDirSector <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: if (start) begin
                    state_q     <= ST_REQ_MBR;
                    readRequest <= 1'b1;
                    readSector  <= 32'd0;
                    busy        <= 1'b1;
                    mountDone   <= 1'b0;
                    mountError  <= 1'b0;
                    errorCode   <= ERR_NONE;
                end
                ST_REQ_MBR: if (readAck) begin
                    readRequest <= 1'b0;
                    state_q     <= ST_RX_MBR;
                end
                ST_RX_MBR: if (sectorDone) state_q <= ST_CHK_MBR;
                ST_CHK_MBR: begin
                    if (mbr_sig != BOOT_SIG || (part_type != PTYPE_FAT32_CHS &&
                                                part_type != PTYPE_FAT32_LBA)) begin
                        state_q    <= ST_ERROR;
                        busy       <= 1'b0;
                        mountError <= 1'b1;
                        errorCode  <= (mbr_sig != BOOT_SIG) ? ERR_MBR_SIG : ERR_PART_TYPE;
                    end else begin
                        state_q     <= ST_REQ_BPB;
                        readRequest <= 1'b1;
                        readSector  <= partitionStart;
                    end
                end
                ST_REQ_BPB: if (readAck) begin
                    readRequest <= 1'b0;
                    state_q     <= ST_RX_BPB;
                end
                ST_RX_BPB: if (sectorDone) state_q <= ST_CHK_BPB;
                ST_CHK_BPB: begin
                    if (bpb_sig != BOOT_SIG || bytes_per_sec != 16'(SECTOR_BYTES) || !geom_ok) begin
                        state_q    <= ST_ERROR;
                        busy       <= 1'b0;
                        mountError <= 1'b1;
                        errorCode  <= (bpb_sig != BOOT_SIG || bytes_per_sec != 16'(SECTOR_BYTES))
                                      ? ERR_BPB : ERR_GEOMETRY;
                    end else begin
                        fatStart  <= partitionStart + {16'd0, ReservedSectors};
                        acc_q     <= partitionStart + {16'd0, ReservedSectors};
                        fat_cnt_q <= num_fats;
                        state_q   <= ST_CALC_FAT;
                    end
                end
                // One FAT copy added per cycle; the last add also lands in dataStart.
                ST_CALC_FAT: begin
                    acc_q     <= acc_q + fat_len;
                    fat_cnt_q <= fat_cnt_q - 8'd1;
                    if (fat_cnt_q == 8'd1) begin
                        dataStart <= acc_q + fat_len;
                        state_q   <= ST_CALC_ROOT;
                    end
                end
                ST_CALC_ROOT: begin
                    rootDirSector <= dataStart +
                                     ((RootClusterNumber - 32'd2) << log2_pow2(SectorsPerCluster));
                    state_q       <= ST_DONE;
                    busy          <= 1'b0;
                    mountDone     <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fat32_volume_mount.sv
// Bench for fat32_volume_mount: builds MBR/BPB images, streams them through
// the byte interface and compares against an arithmetic reference model.
module tb_fat32_volume_mount;

    logic        Clock = 1'b0;
    logic        sys_rst_n, start, readAck, byteValid, sectorDone;
    logic [8:0]  byteAddress;
    logic [7:0]  byteData;
    logic        readRequest, busy, mountDone, mountError;
    logic [31:0] readSector, partitionStart, fatStart, dataStart, rootDirSector, RootClusterNumber;
    logic [2:0]  errorCode;
    logic [7:0]  SectorsPerCluster;
    logic [15:0] ReservedSectors;

    int checks = 0;
    int failures = 0;

    logic [7:0] mbr [512];
    logic [7:0] bpb [512];

    logic [31:0] obs_sec0, obs_sec1;
    bit          obs_req2, obs_timeout;
    int          obs_lat;
    logic        obs_md_start, obs_me_start, obs_busy_start;
    logic [2:0]  obs_ec_start;

    fat32_volume_mount #(.SECTOR_BYTES(512), .ADDR_W(9), .MAX_FATS(4)) dut (
        .Clock(Clock), .sys_rst_n(sys_rst_n), .start(start),
        .readRequest(readRequest), .readSector(readSector), .readAck(readAck),
        .byteValid(byteValid), .byteAddress(byteAddress), .byteData(byteData),
        .sectorDone(sectorDone), .busy(busy), .mountDone(mountDone),
        .mountError(mountError), .errorCode(errorCode),
        .partitionStart(partitionStart), .fatStart(fatStart), .dataStart(dataStart),
        .rootDirSector(rootDirSector), .SectorsPerCluster(SectorsPerCluster),
        .RootClusterNumber(RootClusterNumber), .ReservedSectors(ReservedSectors));

    always #5 Clock = ~Clock;

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic build_card(input logic [31:0] lba, input logic [7:0] ptype,
                              input logic [15:0] bps, input logic [7:0] spc,
                              input logic [15:0] rsv, input logic [7:0] nf,
                              input logic [31:0] flen, input logic [31:0] rc);
        for (int i = 0; i < 512; i++) begin
            mbr[i] = 8'($urandom);
            bpb[i] = 8'($urandom);
        end
        mbr['h1C2] = ptype;
        for (int i = 0; i < 4; i++) begin
            mbr['h1C6 + i] = lba[8*i +: 8];
            bpb['h24 + i]  = flen[8*i +: 8];
            bpb['h2C + i]  = rc[8*i +: 8];
        end
        mbr['h1FE] = 8'h55; mbr['h1FF] = 8'hAA;
        bpb['h0B] = bps[7:0]; bpb['h0C] = bps[15:8];
        bpb['h0D] = spc;
        bpb['h0E] = rsv[7:0]; bpb['h0F] = rsv[15:8];
        bpb['h10] = nf;
        bpb['h1FE] = 8'h55; bpb['h1FF] = 8'hAA;
    endtask

    // Reference: mount result computed straight from the sector images.
    function automatic void model(output logic [2:0] ec, output logic [31:0] fs,
                                  output logic [31:0] ds, output logic [31:0] rd);
        logic [31:0] lba, flen, rc;
        logic [15:0] bps, rsv;
        logic [7:0]  spc, nf;
        lba  = {mbr['h1C9], mbr['h1C8], mbr['h1C7], mbr['h1C6]};
        flen = {bpb['h27], bpb['h26], bpb['h25], bpb['h24]};
        rc   = {bpb['h2F], bpb['h2E], bpb['h2D], bpb['h2C]};
        bps  = {bpb['h0C], bpb['h0B]};
        rsv  = {bpb['h0F], bpb['h0E]};
        spc  = bpb['h0D];
        nf   = bpb['h10];
        fs = lba + {16'd0, rsv};
        ds = fs + 32'(nf) * flen;
        rd = ds + (rc - 32'd2) * 32'(spc);
        if (mbr['h1FE] != 8'h55 || mbr['h1FF] != 8'hAA) ec = 3'd1;
        else if (!(mbr['h1C2] inside {8'h0B, 8'h0C})) ec = 3'd2;
        else if (bpb['h1FE] != 8'h55 || bpb['h1FF] != 8'hAA || bps != 16'd512) ec = 3'd3;
        else if (!(spc inside {8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd128}) ||
                 nf < 8'd1 || nf > 8'd4 || rc < 32'd2) ec = 3'd4;
        else ec = 3'd0;
    endfunction

    task automatic send_sector(input bit which, input bit start_mid, input int stop_at);
        bit merge;
        merge = 1'($urandom_range(0, 1));
        // A junk signature byte first; the real one arrives later and must win.
        byteValid = 1'b1; byteAddress = 9'h1FE; byteData = 8'h00;
        step();
        for (int a = 0; a < 512; a++) begin
            if (a == stop_at) begin
                byteValid = 1'b0;
                return;
            end
            if ($urandom_range(0, 7) == 0) begin
                byteValid = 1'b0;
                step();
            end
            byteValid   = 1'b1;
            byteAddress = 9'(a);
            byteData    = which ? bpb[a] : mbr[a];
            sectorDone  = merge && (a == 511);
            start       = start_mid && (a == 100);
            step();
        end
        byteValid = 1'b0; start = 1'b0; sectorDone = 1'b0;
        if (!merge) begin
            sectorDone = 1'b1;
            step();
            sectorDone = 1'b0;
        end
    endtask

    task automatic run_mount(input bit start_mid);
        int n;
        obs_timeout = 0; obs_req2 = 0; obs_lat = -1; obs_sec0 = '1; obs_sec1 = '1;
        start = 1'b1;
        step();
        start = 1'b0;
        obs_md_start = mountDone; obs_me_start = mountError;
        obs_ec_start = errorCode; obs_busy_start = busy;
        n = 0;
        while (!readRequest && n < 10) begin step(); n++; end
        if (!readRequest) begin obs_timeout = 1; return; end
        obs_sec0 = readSector;
        repeat ($urandom_range(0, 3)) step();
        readAck = 1'b1; step(); readAck = 1'b0;
        send_sector(1'b0, start_mid, -1);
        n = 0;
        while (!readRequest && !mountError && n < 10) begin step(); n++; end
        if (mountError) begin
            repeat (5) begin step(); if (readRequest) obs_req2 = 1; end
            return;
        end
        if (!readRequest) begin obs_timeout = 1; return; end
        obs_req2 = 1;
        obs_sec1 = readSector;
        repeat ($urandom_range(0, 3)) step();
        readAck = 1'b1; step(); readAck = 1'b0;
        send_sector(1'b1, 1'b0, -1);
        n = 0;
        while (!mountDone && !mountError && n < 40) begin step(); n++; end
        if (mountDone) obs_lat = n;
        else if (!mountError) obs_timeout = 1;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        step(); step();
        checks++; if ({readRequest, busy, mountDone, mountError} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {readRequest, busy, mountDone, mountError}); end
        checks++; if (errorCode !== 3'd0 || readSector !== 32'd0) begin failures++; $display("FAIL reset_code_sector got=%0d/%h exp=0/0", errorCode, readSector); end
        sys_rst_n = 1'b1;
        step();
    endtask

    task automatic test_valid_card();
        build_card(32'h2000, 8'h0C, 16'd512, 8'd8, 16'd32, 8'd2, 32'h3C1, 32'd2);
        run_mount(1'b0);
        checks++; if (obs_timeout !== 1'b0) begin failures++; $display("FAIL valid_timeout got=1 exp=0"); end
        checks++; if (obs_sec0 !== 32'd0) begin failures++; $display("FAIL valid_sector0 got=%h exp=0", obs_sec0); end
        checks++; if (obs_sec1 !== 32'h2000) begin failures++; $display("FAIL valid_sector1 got=%h exp=2000", obs_sec1); end
        checks++; if (fatStart !== 32'h2020) begin failures++; $display("FAIL valid_fatStart got=%h exp=2020", fatStart); end
        checks++; if (dataStart !== 32'h27A2) begin failures++; $display("FAIL valid_dataStart got=%h exp=27a2", dataStart); end
        checks++; if (rootDirSector !== 32'h27A2) begin failures++; $display("FAIL valid_rootDir got=%h exp=27a2", rootDirSector); end
        checks++; if (obs_lat !== 4) begin failures++; $display("FAIL valid_latency got=%0d exp=4", obs_lat); end
        checks++; if ({mountDone, mountError, busy} !== 3'b100 || errorCode !== 3'd0) begin failures++; $display("FAIL valid_status got=%b/%0d exp=100/0", {mountDone, mountError, busy}, errorCode); end
        checks++; if (SectorsPerCluster !== 8'd8 || ReservedSectors !== 16'd32 || RootClusterNumber !== 32'd2 || partitionStart !== 32'h2000) begin failures++; $display("FAIL valid_fields got=%0d/%0d/%0d/%h exp=8/32/2/2000", SectorsPerCluster, ReservedSectors, RootClusterNumber, partitionStart); end
    endtask

    task automatic test_restart_root5();
        build_card(32'h2000, 8'h0C, 16'd512, 8'd8, 16'd32, 8'd2, 32'h3C1, 32'd5);
        run_mount(1'b0);
        checks++; if (obs_md_start !== 1'b0 || obs_busy_start !== 1'b1) begin failures++; $display("FAIL restart_done got md=%b busy=%b exp md=0 busy=1", obs_md_start, obs_busy_start); end
        checks++; if (obs_sec0 !== 32'd0) begin failures++; $display("FAIL restart_sector0 got=%h exp=0", obs_sec0); end
        checks++; if (rootDirSector !== 32'h27BA) begin failures++; $display("FAIL root5_rootDir got=%h exp=27ba", rootDirSector); end
    endtask

    task automatic test_start_in_rx();
        build_card(32'h0001_0000, 8'h0B, 16'd512, 8'd1, 16'd6, 8'd1, 32'h100, 32'd9);
        run_mount(1'b1);
        checks++; if (obs_sec1 !== 32'h0001_0000) begin failures++; $display("FAIL startrx_sector1 got=%h exp=10000", obs_sec1); end
        checks++; if (rootDirSector !== 32'h0001_010D || obs_lat !== 3) begin failures++; $display("FAIL startrx_result got=%h lat=%0d exp=1010d lat=3", rootDirSector, obs_lat); end
    endtask

    task automatic test_mbr_sig_error();
        build_card(32'h2000, 8'h0C, 16'd512, 8'd8, 16'd32, 8'd2, 32'h3C1, 32'd2);
        mbr['h1FF] = 8'hAB;
        run_mount(1'b0);
        checks++; if (mountError !== 1'b1 || errorCode !== 3'd1) begin failures++; $display("FAIL mbrsig_error got=%b/%0d exp=1/1", mountError, errorCode); end
        checks++; if (obs_req2 !== 1'b0 || mountDone !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mbrsig_noreq got=%b/%b/%b exp=0/0/0", obs_req2, mountDone, busy); end
    endtask

    task automatic test_bpb_errors();
        build_card(32'h2000, 8'h0C, 16'd512, 8'd6, 16'd32, 8'd2, 32'h3C1, 32'd2);
        run_mount(1'b0);
        checks++; if (obs_me_start !== 1'b0 || obs_ec_start !== 3'd0) begin failures++; $display("FAIL restart_error got=%b/%0d exp=0/0", obs_me_start, obs_ec_start); end
        checks++; if (mountError !== 1'b1 || errorCode !== 3'd4) begin failures++; $display("FAIL spc6 got=%b/%0d exp=1/4", mountError, errorCode); end
        build_card(32'h2000, 8'h0C, 16'd1024, 8'd8, 16'd32, 8'd2, 32'h3C1, 32'd2);
        run_mount(1'b0);
        checks++; if (mountError !== 1'b1 || errorCode !== 3'd3) begin failures++; $display("FAIL bps1024 got=%b/%0d exp=1/3", mountError, errorCode); end
        build_card(32'h2000, 8'h07, 16'd512, 8'd8, 16'd32, 8'd2, 32'h3C1, 32'd2);
        run_mount(1'b0);
        checks++; if (errorCode !== 3'd2 || obs_req2 !== 1'b0) begin failures++; $display("FAIL ptype got=%0d req2=%b exp=2 req2=0", errorCode, obs_req2); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            logic [31:0] lba, flen, rc, fs, ds, rd;
            logic [7:0]  spc, nf, ptype;
            logic [15:0] bps, rsv;
            logic [2:0]  ec;
            int          sel;
            lba   = $urandom;
            ptype = $urandom_range(0, 1) ? 8'h0B : 8'h0C;
            bps   = 16'd512;
            spc   = 8'(1 << $urandom_range(0, 7));
            rsv   = 16'($urandom_range(1, 64));
            nf    = 8'($urandom_range(1, 4));
            flen  = $urandom_range(1, 'hFFFF);
            rc    = $urandom_range(2, 1000);
            sel   = $urandom_range(0, 9);
            case (sel)
                2: bps = 16'd1024;
                3: spc = 8'd3;
                4: nf = $urandom_range(0, 1) ? 8'd0 : 8'd5;
                5: rc = $urandom_range(0, 1);
                6: ptype = 8'h83;
                default: ;
            endcase
            build_card(lba, ptype, bps, spc, rsv, nf, flen, rc);
            if (sel == 1) mbr['h1FE] = 8'h54;
            if (sel == 7) bpb['h1FF] = 8'h00;
            model(ec, fs, ds, rd);
            run_mount(1'b0);
            checks++; if (errorCode !== ec || mountDone !== (ec == 3'd0)) begin failures++; $display("FAIL rand%0d_code got=%0d/%b exp=%0d", it, errorCode, mountDone, ec); end
            if (ec == 3'd0) begin
                checks++; if (fatStart !== fs || dataStart !== ds || rootDirSector !== rd) begin failures++; $display("FAIL rand%0d_addr got=%h/%h/%h exp=%h/%h/%h", it, fatStart, dataStart, rootDirSector, fs, ds, rd); end
                checks++; if (obs_lat !== 2 + int'(nf)) begin failures++; $display("FAIL rand%0d_lat got=%0d exp=%0d", it, obs_lat, 2 + int'(nf)); end
            end else if (ec >= 3'd3) begin
                checks++; if (obs_sec1 !== lba) begin failures++; $display("FAIL rand%0d_sector1 got=%h exp=%h", it, obs_sec1, lba); end
            end else begin
                checks++; if (obs_req2 !== 1'b0) begin failures++; $display("FAIL rand%0d_noreq got=1 exp=0", it); end
            end
        end
    endtask

    task automatic test_reset_mid_bpb();
        int n;
        build_card(32'h0000_4000, 8'h0C, 16'd512, 8'd16, 16'd8, 8'd3, 32'h20, 32'd4);
        start = 1'b1; step(); start = 1'b0;
        n = 0; while (!readRequest && n < 10) begin step(); n++; end
        readAck = 1'b1; step(); readAck = 1'b0;
        send_sector(1'b0, 1'b0, -1);
        n = 0; while (!readRequest && n < 10) begin step(); n++; end
        checks++; if (readRequest !== 1'b1) begin failures++; $display("FAIL rstmid_bpbreq got=%b exp=1", readRequest); end
        readAck = 1'b1; step(); readAck = 1'b0;
        send_sector(1'b1, 1'b0, 200);
        byteValid = 1'b1; byteAddress = 9'h0D; byteData = 8'h03;
        sys_rst_n = 1'b0;
        step(); step();
        checks++; if ({readRequest, busy, mountDone, mountError, errorCode} !== 7'd0 || readSector !== 32'd0) begin failures++; $display("FAIL rstmid_ctrl got=%b/%h exp=0/0", {readRequest, busy, mountDone, mountError, errorCode}, readSector); end
        checks++; if ({fatStart, dataStart, rootDirSector, partitionStart} !== 128'd0) begin failures++; $display("FAIL rstmid_addrs got=%h/%h/%h/%h exp=0", fatStart, dataStart, rootDirSector, partitionStart); end
        checks++; if ({SectorsPerCluster, ReservedSectors, RootClusterNumber} !== 56'd0) begin failures++; $display("FAIL rstmid_fields got=%h/%h/%h exp=0", SectorsPerCluster, ReservedSectors, RootClusterNumber); end
        sys_rst_n = 1'b1;
        step(); step();
        byteValid = 1'b0;
        checks++; if (SectorsPerCluster !== 8'd0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_idlebytes got spc=%0d busy=%b exp=0/0", SectorsPerCluster, busy); end
        run_mount(1'b0);
        checks++; if (obs_sec0 !== 32'd0 || obs_timeout !== 1'b0) begin failures++; $display("FAIL rstmid_rereq got=%h to=%b exp=0/0", obs_sec0, obs_timeout); end
        checks++; if (rootDirSector !== 32'h0000_4088 || obs_lat !== 5) begin failures++; $display("FAIL rstmid_result got=%h lat=%0d exp=4088 lat=5", rootDirSector, obs_lat); end
    endtask

    initial begin
        sys_rst_n = 1'b0; start = 1'b0; readAck = 1'b0; byteValid = 1'b0;
        sectorDone = 1'b0; byteAddress = '0; byteData = '0;
        test_reset();
        test_valid_card();
        test_restart_root5();
        test_start_in_rx();
        test_mbr_sig_error();
        test_bpb_errors();
        test_random();
        test_reset_mid_bpb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
